// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: display states, hex glyph table and idle-animation frames.
package seg_pkg;

  typedef enum logic {
    COUNT   = 1'b0,
    ANIMATE = 1'b1
  } state_t;

  // Segment bit order: bit0=a ... bit6=g, active high.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_A = 7'h01;
  localparam logic [6:0] SEG_B = 7'h02;
  localparam logic [6:0] SEG_C = 7'h04;
  localparam logic [6:0] SEG_D = 7'h08;
  localparam logic [6:0] SEG_E = 7'h10;
  localparam logic [6:0] SEG_F = 7'h20;

  localparam logic [2:0] ANIM_LAST = 3'd5;

  function automatic logic [6:0] anim_frame(input logic [2:0] idx);
    logic [6:0] f;
    f = 7'h00;
    case (idx)
      3'd0:    f = SEG_A;
      3'd1:    f = SEG_B;
      3'd2:    f = SEG_C;
      3'd3:    f = SEG_D;
      3'd4:    f = SEG_E;
      3'd5:    f = SEG_F;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/pulse_counter_display_if.sv
// Press pulse in, segment/decimal-point/status out; master drives the pulse, slave is the display.
interface pulse_counter_display_if;
  logic       pulse_in;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       state_out;

  modport master (output pulse_in, input seg_out, dp_out, state_out);
  modport slave  (input pulse_in, output seg_out, dp_out, state_out);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational 4-bit hex to active-high seven-segment pattern; zero latency, no flow control.
module seg7_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/pulse_counter_display.sv
// Press counter on one hex digit with decimal-point feedback and an idle segment animation.
// Outputs registered: one cycle from a pulse_in sample to a visible change; no backpressure.
module pulse_counter_display
  import seg_pkg::*;
#(
  parameter int MAX_COUNT   = 10,
  parameter int IDLE_CYCLES = 50_000_000,
  parameter int ANIM_STEP   = 5_000_000,
  parameter int DP_HOLD     = 2_500_000
) (
  input  logic                    clk,
  input  logic                    reset,
  pulse_counter_display_if.slave  bus
);

  localparam int CW = (MAX_COUNT   > 1) ? $clog2(MAX_COUNT)   : 1;
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int SW = (ANIM_STEP   > 1) ? $clog2(ANIM_STEP)   : 1;
  // dp_cnt has to hold DP_HOLD itself, not just DP_HOLD-1.
  localparam int DW = $clog2(DP_HOLD + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idle_q,  idle_d;
  logic [SW-1:0] step_q,  step_d;
  logic [2:0]    anim_q,  anim_d;
  logic [DW-1:0] dp_q,    dp_d;
  logic [6:0]    dec_seg, seg_d;

  seg7_decoder u_dec (
    .hex (4'(count_d)),
    .seg (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idle_d  = idle_q;
    step_d  = step_q;
    anim_d  = anim_q;
    dp_d    = (dp_q != '0) ? dp_q - 1'b1 : dp_q;

    unique case (state_q)
      COUNT: begin
        // A press on the timeout cycle is counted and keeps us in COUNT.
        if (bus.pulse_in) begin
          count_d = (count_q == CW'(MAX_COUNT - 1)) ? '0 : count_q + 1'b1;
          idle_d  = '0;
          dp_d    = DW'(DP_HOLD);
        end else if (idle_q == IW'(IDLE_CYCLES - 1)) begin
          state_d = ANIMATE;
          idle_d  = '0;
          step_d  = '0;
          anim_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ANIMATE: begin
        // Wake-up press is consumed: count and dp feedback untouched.
        if (bus.pulse_in) begin
          state_d = COUNT;
          idle_d  = '0;
        end else if (step_q == SW'(ANIM_STEP - 1)) begin
          step_d = '0;
          anim_d = (anim_q == ANIM_LAST) ? 3'd0 : anim_q + 3'd1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = COUNT;
    endcase

    seg_d = (state_d == ANIMATE) ? anim_frame(anim_d) : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= COUNT;
      count_q       <= '0;
      idle_q        <= '0;
      step_q        <= '0;
      anim_q        <= '0;
      dp_q          <= '0;
      bus.seg_out   <= HEX_SEG[0];
      bus.dp_out    <= 1'b0;
      bus.state_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idle_q        <= idle_d;
      step_q        <= step_d;
      anim_q        <= anim_d;
      dp_q          <= dp_d;
      bus.seg_out   <= seg_d;
      bus.dp_out    <= (dp_d != '0);
      bus.state_out <= (state_d == ANIMATE);
    end
  end

endmodule

// File: tb/tb_pulse_counter_display.sv
// Directed bench: vector table for reset/press/wrap, hand sequences for idle animation and wake-up.
module tb_pulse_counter_display;

  typedef struct {
    logic       rst;
    logic       p;
    logic [6:0] seg;
    logic       dp;
    logic       st;
  } vec_t;

  localparam logic [6:0] DIG [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  pulse_counter_display_if bus ();

  pulse_counter_display #(
    .MAX_COUNT   (10),
    .IDLE_CYCLES (20),
    .ANIM_STEP   (3),
    .DP_HOLD     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, input logic p, input logic [6:0] s,
                     input logic d, input logic st);
    vec_t v;
    v.rst = r; v.p = p; v.seg = s; v.dp = d; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic r, input logic p);
    @(negedge clk);
    reset        = r;
    bus.pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [6:0] s, input logic d, input logic st);
    tests++;
    if (bus.seg_out !== s || bus.dp_out !== d || bus.state_out !== st) begin
      fails++;
      $display("FAIL %s: got seg=%h dp=%b st=%b, expected seg=%h dp=%b st=%b",
               nm, bus.seg_out, bus.dp_out, bus.state_out, s, d, st);
    end
  endtask

  initial begin
    logic [6:0] one;
    one          = 7'h01;
    reset        = 1'b1;
    bus.pulse_in = 1'b0;

    // Reset, idle, single press with 4-cycle dp.
    add(1, 0, 7'h3F, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 7'h3F, 0, 0);
    add(0, 1, 7'h06, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 7'h06, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 7'h06, 0, 0);
    // Ten presses two apart from zero: 1..9 then wrap to 0, dp held throughout.
    add(1, 0, 7'h3F, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      add(0, 1, DIG[k % 10], 1, 0);
      if (k < 10) add(0, 0, DIG[k], 1, 0);
    end
    for (int i = 0; i < 3; i++) add(0, 0, 7'h3F, 1, 0);
    add(0, 0, 7'h3F, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].p);
      check($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp, vecs[i].st);
    end

    // Count to 3, then exact idle timeout and animation frames.
    apply(1, 0);
    check("rst2", 7'h3F, 0, 0);
    apply(0, 1); apply(0, 0); apply(0, 1); apply(0, 0); apply(0, 1);
    check("count3", 7'h4F, 1, 0);
    for (int i = 0; i < 19; i++) begin
      apply(0, 0);
      check($sformatf("idle%0d", i), 7'h4F, (i < 3), 0);
    end
    apply(0, 0);
    check("anim_enter", 7'h01, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      apply(0, 0);
      check($sformatf("anim%0d", i), one << ((i / 3) % 6), 0, 1);
    end

    // Wake-up press is not counted; next press is.
    apply(0, 1);
    check("wake", 7'h4F, 0, 0);
    apply(0, 1);
    check("after_wake", 7'h66, 1, 0);

    // Press on the timeout cycle wins.
    for (int i = 0; i < 19; i++) apply(0, 0);
    check("pre_timeout", 7'h66, 0, 0);
    apply(0, 1);
    check("tie_press", 7'h6D, 1, 0);

    for (int i = 0; i < 20; i++) apply(0, 0);
    check("anim_again", 7'h01, 0, 1);
    for (int i = 0; i < 4; i++) apply(0, 0);
    check("anim_frame_b", 7'h02, 0, 1);

    // Reset overrides a simultaneous pulse.
    apply(1, 1);
    check("rst_pulse", 7'h3F, 0, 0);
    apply(0, 0);
    check("post_rst", 7'h3F, 0, 0);
    apply(0, 1);
    check("post_rst_press", 7'h06, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
